// File: rtl/watch_pkg.sv
// ---------------------------------------------------------------------------
// watch_pkg
//   Shared definitions for the watch control unit:
//   - edit-mode state encoding (legacy-compatible 2-bit constants)
//   - next_mode(): state sequence RUN -> SEC -> MIN -> HOUR -> RUN
//   - cnt_width(): counter width for a count limit (never below 1 bit)
// ---------------------------------------------------------------------------
package watch_pkg;

   localparam logic [1:0] ST_RUN       = 2'd0;
   localparam logic [1:0] ST_EDIT_SEC  = 2'd1;
   localparam logic [1:0] ST_EDIT_MIN  = 2'd2;
   localparam logic [1:0] ST_EDIT_HOUR = 2'd3;

   // The encoding is a plain 2-bit count, so advancing wraps HOUR back to RUN.
   function automatic logic [1:0] next_mode(input logic [1:0] i_state);
      return i_state + 2'd1;
   endfunction

   function automatic int cnt_width(input int i_limit);
      return (i_limit > 1) ? $clog2(i_limit) : 1;
   endfunction

endpackage

// File: rtl/watch_cu_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Conditions one raw push-button: 2-FF synchronizer, debounce counter and
//   rising-edge detect of the debounced level.
//   Ports:
//     clk      in   system clock
//     rst      in   asynchronous, active-high reset
//     i_btn    in   raw asynchronous button level
//     o_level  out  debounced level
//     o_press  out  one-cycle pulse on the rising edge of o_level
// ---------------------------------------------------------------------------
module btn_debounce
   import watch_pkg::*;
#(
   parameter int DEBOUNCE_COUNT = 100_000
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_level,
   output logic o_press
);

   localparam int              CW     = cnt_width(DEBOUNCE_COUNT);
   localparam logic [CW-1:0]   C_LAST = CW'(DEBOUNCE_COUNT - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_level_d;
   logic [CW-1:0] r_cnt;

   // The counter only ever runs up to DEBOUNCE_COUNT-1: the cycle that would
   // reach DEBOUNCE_COUNT flips the level and clears it instead.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= i_btn;
         r_sync2   <= r_sync1;
         r_level_d <= r_level;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == C_LAST) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_level;
   assign o_press = r_level & ~r_level_d;

endmodule

// File: rtl/watch_cu.sv
// ---------------------------------------------------------------------------
// watch_cu
//   Edit-mode control unit for the watch datapath. Debounces the mode/up/down
//   buttons, steps RUN -> EDIT_SEC -> EDIT_MIN -> EDIT_HOUR -> RUN on each mode
//   press, and issues one-cycle up/down strobes with auto-repeat while held.
//   Ports:
//     clk, rst           clock, asynchronous active-high reset
//     btn_mode           raw mode button
//     btn_up_raw         raw up button
//     btn_down_raw       raw down button
//     o_sel_sec/min/hour registered one-hot field select (all 0 in RUN)
//     o_btn_up/down      one-cycle increment / decrement strobes
//     o_edit             high in any edit state
// ---------------------------------------------------------------------------
module watch_cu
   import watch_pkg::*;
#(
   parameter int DEBOUNCE_COUNT = 100_000,
   parameter int REPEAT_DELAY   = 50_000_000,
   parameter int REPEAT_PERIOD  = 10_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_mode,
   input  logic btn_up_raw,
   input  logic btn_down_raw,
   output logic o_sel_sec,
   output logic o_sel_min,
   output logic o_sel_hour,
   output logic o_btn_up,
   output logic o_btn_down,
   output logic o_edit
);

   localparam int            RW       = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ?
                                                  REPEAT_DELAY : REPEAT_PERIOD);
   localparam logic [RW-1:0] R_DLY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] R_PER_LAST = RW'(REPEAT_PERIOD - 1);

   logic w_mode_level_unused;
   logic w_mode_press;
   logic w_up_level;
   logic w_up_press;
   logic w_dn_level;
   logic w_dn_press;

   btn_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_db_mode (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (btn_mode),
      .o_level (w_mode_level_unused),
      .o_press (w_mode_press)
   );

   btn_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_db_up (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (btn_up_raw),
      .o_level (w_up_level),
      .o_press (w_up_press)
   );

   btn_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_db_down (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (btn_down_raw),
      .o_level (w_dn_level),
      .o_press (w_dn_press)
   );

   logic [1:0]    r_state;
   logic          r_sel_sec;
   logic          r_sel_min;
   logic          r_sel_hour;
   logic          r_up;
   logic          r_dn;
   logic          r_rep_act;    // auto-repeat armed
   logic          r_rep_dir;    // 1 = up, 0 = down
   logic          r_rep_first;  // waiting for the first (long) repeat gap
   logic [RW-1:0] r_rep_cnt;

   logic [1:0]    w_state_nxt;
   logic          w_up_nxt;
   logic          w_dn_nxt;
   logic          w_rep_act_nxt;
   logic          w_rep_dir_nxt;
   logic          w_rep_first_nxt;
   logic [RW-1:0] w_rep_cnt_nxt;
   logic          w_hold_up;
   logic          w_hold_dn;

   // Holding both buttons qualifies neither for repeat.
   assign w_hold_up = w_up_level & ~w_dn_level;
   assign w_hold_dn = w_dn_level & ~w_up_level;

   // Priority: mode press > RUN / simultaneous up+down > new press > repeat.
   // The repeat counter restarts at 0 on every strobe and is compared against
   // (gap - 1), so it never exceeds its limit while the button is held.
   always_comb begin
      w_state_nxt     = r_state;
      w_up_nxt        = 1'b0;
      w_dn_nxt        = 1'b0;
      w_rep_act_nxt   = r_rep_act;
      w_rep_dir_nxt   = r_rep_dir;
      w_rep_first_nxt = r_rep_first;
      w_rep_cnt_nxt   = r_rep_cnt;
      if (w_mode_press) begin
         w_state_nxt   = next_mode(r_state);
         w_rep_act_nxt = 1'b0;
         w_rep_cnt_nxt = '0;
      end else if ((r_state == ST_RUN) || (w_up_press && w_dn_press)) begin
         w_rep_act_nxt = 1'b0;
         w_rep_cnt_nxt = '0;
      end else if (w_up_press || w_dn_press) begin
         w_up_nxt        = w_up_press;
         w_dn_nxt        = w_dn_press;
         w_rep_act_nxt   = 1'b1;
         w_rep_dir_nxt   = w_up_press;
         w_rep_first_nxt = 1'b1;
         w_rep_cnt_nxt   = '0;
      end else if (r_rep_act) begin
         if (r_rep_dir ? w_hold_up : w_hold_dn) begin
            if (r_rep_cnt == (r_rep_first ? R_DLY_LAST : R_PER_LAST)) begin
               w_up_nxt        = r_rep_dir;
               w_dn_nxt        = ~r_rep_dir;
               w_rep_first_nxt = 1'b0;
               w_rep_cnt_nxt   = '0;
            end else begin
               w_rep_cnt_nxt = r_rep_cnt + 1'b1;
            end
         end else begin
            w_rep_act_nxt = 1'b0;
            w_rep_cnt_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_sel_sec   <= 1'b0;
         r_sel_min   <= 1'b0;
         r_sel_hour  <= 1'b0;
         r_up        <= 1'b0;
         r_dn        <= 1'b0;
         r_rep_act   <= 1'b0;
         r_rep_dir   <= 1'b0;
         r_rep_first <= 1'b0;
         r_rep_cnt   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         // Decoded from the next state so selects move on the strobe cycle.
         r_sel_sec   <= (w_state_nxt == ST_EDIT_SEC);
         r_sel_min   <= (w_state_nxt == ST_EDIT_MIN);
         r_sel_hour  <= (w_state_nxt == ST_EDIT_HOUR);
         r_up        <= w_up_nxt;
         r_dn        <= w_dn_nxt;
         r_rep_act   <= w_rep_act_nxt;
         r_rep_dir   <= w_rep_dir_nxt;
         r_rep_first <= w_rep_first_nxt;
         r_rep_cnt   <= w_rep_cnt_nxt;
      end
   end

   assign o_sel_sec  = r_sel_sec;
   assign o_sel_min  = r_sel_min;
   assign o_sel_hour = r_sel_hour;
   assign o_btn_up   = r_up;
   assign o_btn_down = r_dn;
   assign o_edit     = r_sel_sec | r_sel_min | r_sel_hour;

endmodule

// File: tb/tb_watch_cu.sv
// ---------------------------------------------------------------------------
// tb_watch_cu
//   Self-checking bench for watch_cu (DEBOUNCE_COUNT=4, REPEAT_DELAY=20,
//   REPEAT_PERIOD=5). A behavioural model derives the debounced levels from a
//   window of raw samples and repeat strobes from absolute cycle timestamps;
//   outputs are compared against it every cycle. Directed scenarios add
//   literal latency / pulse-count expectations, then random stimulus runs.
// ---------------------------------------------------------------------------
module tb_watch_cu;

   localparam int D  = 4;
   localparam int RD = 20;
   localparam int RP = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_mode = 1'b0;
   logic btn_up_raw = 1'b0;
   logic btn_down_raw = 1'b0;
   logic o_sel_sec, o_sel_min, o_sel_hour, o_btn_up, o_btn_down, o_edit;

   always #5 clk = ~clk;

   watch_cu #(
      .DEBOUNCE_COUNT (D),
      .REPEAT_DELAY   (RD),
      .REPEAT_PERIOD  (RP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_mode     (btn_mode),
      .btn_up_raw   (btn_up_raw),
      .btn_down_raw (btn_down_raw),
      .o_sel_sec    (o_sel_sec),
      .o_sel_min    (o_sel_min),
      .o_sel_hour   (o_sel_hour),
      .o_btn_up     (o_btn_up),
      .o_btn_down   (o_btn_down),
      .o_edit       (o_edit)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s @t=%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int cyc = 0;                 // count of non-reset clock edges
   int m_state;                 // 0 RUN, 1 SEC, 2 MIN, 3 HOUR
   bit m_up, m_dn;
   bit m_rep_on, m_rep_up;
   int m_next;                  // edge index of the next due repeat strobe
   bit lvl_now [3];             // 0 mode, 1 up, 2 down
   bit lvl_old [3];
   bit hist [3][D+2];           // hist[b][i] = raw sample from i+1 edges ago

   task automatic model_clear();
      m_state  = 0;
      m_up     = 0;
      m_dn     = 0;
      m_rep_on = 0;
      m_rep_up = 0;
      m_next   = 0;
      for (int b = 0; b < 3; b++) begin
         lvl_now[b] = 0;
         lvl_old[b] = 0;
         for (int i = 0; i < D + 2; i++) hist[b][i] = 0;
      end
   endtask

   always @(posedge clk or posedge rst) begin : model
      bit raw [3];
      bit mode_p, up_p, dn_p, hu, hd, flip;
      if (rst) begin
         model_clear();
      end else begin
         cyc++;
         raw[0] = btn_mode;
         raw[1] = btn_up_raw;
         raw[2] = btn_down_raw;
         mode_p = lvl_now[0] & ~lvl_old[0];
         up_p   = lvl_now[1] & ~lvl_old[1];
         dn_p   = lvl_now[2] & ~lvl_old[2];
         hu     = lvl_now[1] & ~lvl_now[2];
         hd     = lvl_now[2] & ~lvl_now[1];
         m_up = 0;
         m_dn = 0;
         if (mode_p) begin
            m_state  = (m_state + 1) % 4;
            m_rep_on = 0;
         end else if (m_state == 0 || (up_p && dn_p)) begin
            m_rep_on = 0;
         end else if (up_p || dn_p) begin
            m_up     = up_p;
            m_dn     = dn_p;
            m_rep_on = 1;
            m_rep_up = up_p;
            m_next   = cyc + RD;
         end else if (m_rep_on) begin
            if (m_rep_up ? hu : hd) begin
               if (cyc == m_next) begin
                  m_up   = m_rep_up;
                  m_dn   = !m_rep_up;
                  m_next = cyc + RP;
               end
            end else begin
               m_rep_on = 0;
            end
         end
         // Debounced level flips when the last D synchronized samples
         // (raw delayed by two edges) all disagree with it.
         for (int b = 0; b < 3; b++) begin
            flip = 1;
            for (int i = 1; i <= D; i++) if (hist[b][i] == lvl_now[b]) flip = 0;
            lvl_old[b] = lvl_now[b];
            if (flip) lvl_now[b] = !lvl_now[b];
            for (int i = D + 1; i > 0; i--) hist[b][i] = hist[b][i-1];
            hist[b][0] = raw[b];
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int n_up = 0, n_dn = 0;
   int up_t[$], dn_t[$];
   int sel_t = 0;
   logic [2:0] prev_sel = 3'b000;

   always @(negedge clk) begin
      chk("sel_sec",  int'(o_sel_sec),  int'(m_state == 1));
      chk("sel_min",  int'(o_sel_min),  int'(m_state == 2));
      chk("sel_hour", int'(o_sel_hour), int'(m_state == 3));
      chk("edit",     int'(o_edit),     int'(m_state != 0));
      chk("btn_up",   int'(o_btn_up),   int'(m_up));
      chk("btn_down", int'(o_btn_down), int'(m_dn));
      chk("up_dn_excl", int'(o_btn_up & o_btn_down), 0);
      if (o_btn_up === 1'b1) begin n_up++; up_t.push_back(cyc); end
      if (o_btn_down === 1'b1) begin n_dn++; dn_t.push_back(cyc); end
      if ({o_sel_hour, o_sel_min, o_sel_sec} !== prev_sel) sel_t = cyc;
      prev_sel = {o_sel_hour, o_sel_min, o_sel_sec};
   end

   // ---------------- stimulus ----------------
   int t_drv;

   task automatic drive3(input bit m, input bit u, input bit d, input int hi, input int lo);
      @(negedge clk);
      btn_mode = m; btn_up_raw = u; btn_down_raw = d;
      t_drv = cyc;
      repeat (hi) @(negedge clk);
      btn_mode = 0; btn_up_raw = 0; btn_down_raw = 0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic mode_step(input string name, input logic [2:0] exp_sel);
      drive3(1, 0, 0, 10, 10);
      chk({name, "_sel"}, int'({o_sel_hour, o_sel_min, o_sel_sec}), int'(exp_sel));
      chk({name, "_latency"}, sel_t - t_drv, 7);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int base_up, base_dn, cd[3];
      repeat (3) @(negedge clk);
      rst = 0;
      repeat (50) @(negedge clk);
      chk("idle_edit", int'(o_edit), 0);
      chk("idle_strobes", n_up + n_dn, 0);

      // Mode cycling RUN -> SEC -> MIN -> HOUR -> RUN
      mode_step("m1", 3'b001);
      mode_step("m2", 3'b010);
      mode_step("m3", 3'b100);
      mode_step("m4", 3'b000);

      // EDIT_MIN: glitch then clean up press
      mode_step("m5", 3'b001);
      mode_step("m6", 3'b010);
      base_up = n_up; base_dn = n_dn;
      drive3(0, 1, 0, 3, 10);
      chk("glitch_up", n_up - base_up, 0);
      drive3(0, 1, 0, 10, 10);
      chk("clean_up_count", n_up - base_up, 1);
      chk("clean_up_latency", up_t[$] - t_drv, 7);
      chk("clean_up_no_down", n_dn - base_dn, 0);

      // EDIT_SEC: held down auto-repeat
      mode_step("m7", 3'b100);
      mode_step("m8", 3'b000);
      mode_step("m9", 3'b001);
      dn_t.delete();
      drive3(0, 0, 1, 35, 20);
      chk("rep_count", dn_t.size(), 4);
      if (dn_t.size() == 4) begin
         chk("rep_t0", dn_t[0] - t_drv, 7);
         chk("rep_gap1", dn_t[1] - dn_t[0], 20);
         chk("rep_gap2", dn_t[2] - dn_t[1], 5);
         chk("rep_gap3", dn_t[3] - dn_t[2], 5);
      end

      // RUN ignores up
      mode_step("m10", 3'b010);
      mode_step("m11", 3'b100);
      mode_step("m12", 3'b000);
      base_up = n_up;
      drive3(0, 1, 0, 10, 10);
      chk("run_up_ignored", n_up - base_up, 0);

      // Simultaneous up+down in EDIT_SEC
      mode_step("m13", 3'b001);
      base_up = n_up; base_dn = n_dn;
      drive3(0, 1, 1, 30, 10);
      chk("updn_same_cycle", (n_up - base_up) + (n_dn - base_dn), 0);

      // Mode and up together in EDIT_SEC
      base_up = n_up;
      drive3(1, 1, 0, 10, 10);
      chk("mode_up_sel", int'({o_sel_hour, o_sel_min, o_sel_sec}), 3'b010);
      chk("mode_up_no_strobe", n_up - base_up, 0);

      // Reset while holding up in EDIT_HOUR
      mode_step("m14", 3'b100);
      base_up = n_up;
      @(negedge clk);
      btn_up_raw = 1;
      repeat (15) @(negedge clk);
      chk("pre_rst_up_count", n_up - base_up, 1);
      chk("pre_rst_hour", int'(o_sel_hour), 1);
      #2 rst = 1;
      #1;
      chk("rst_async_outputs",
          int'({o_sel_sec, o_sel_min, o_sel_hour, o_btn_up, o_btn_down, o_edit}), 0);
      repeat (2) @(negedge clk);
      #2 rst = 0;
      base_up = n_up;
      repeat (40) @(negedge clk);
      chk("post_rst_up_ignored", n_up - base_up, 0);
      chk("post_rst_run", int'({o_sel_hour, o_sel_min, o_sel_sec}), 0);
      btn_up_raw = 0;
      repeat (10) @(negedge clk);

      // Randomized phase: independent random hold times per button
      cd[0] = 40; cd[1] = 5; cd[2] = 9;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (n == 1500) #2 rst = 1;
         if (n == 1503) #2 rst = 0;
         for (int b = 0; b < 3; b++) begin
            cd[b]--;
            if (cd[b] <= 0) begin
               case (b)
                  0: begin btn_mode = ~btn_mode; cd[b] = int'($urandom_range(3, 90)); end
                  1: begin btn_up_raw = ~btn_up_raw; cd[b] = int'($urandom_range(1, 45)); end
                  default: begin btn_down_raw = ~btn_down_raw; cd[b] = int'($urandom_range(1, 45)); end
               endcase
            end
         end
      end
      btn_mode = 0; btn_up_raw = 0; btn_down_raw = 0;
      repeat (20) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
